// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU memory-side units.
// Fetch FSM states, fetch error codes and bus word geometry.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } fetch_err_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mips_cpu_byte_swap.sv
// Combinational 32-bit byte-order reversal, bypassed when EN=0.
// Shared by the instruction fetch and data-memory paths.
module mips_cpu_byte_swap #(
    parameter bit EN = 1'b1
) (
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    if (EN) begin : g_swap
        assign data_o = {data_i[7:0], data_i[15:8],
                         data_i[23:16], data_i[31:24]};
    end else begin : g_pass
        assign data_o = data_i;
    end

endmodule

// File: rtl/mips_cpu_fetch_unit.sv
// Instruction fetch: one Avalon-MM word read per request, then a
// valid/ready hand-off to the instruction register.
module mips_cpu_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter bit BYTE_SWAP      = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr_word,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        fetch_error,
    output logic [1:0]  error_code
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
    localparam int AW = $clog2(WORD_BYTES);

    fetch_state_t  state_q;
    fetch_err_t    code_q;
    logic [31:0]   addr_q;
    logic [31:0]   instr_q;
    logic          read_q;
    logic          valid_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   rd_swapped;

    mips_cpu_byte_swap #(
        .EN (BYTE_SWAP)
    ) u_swap (
        .data_i (avm_readdata),
        .data_o (rd_swapped)
    );

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= ERR_NONE;
            addr_q  <= '0;
            instr_q <= '0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_req) begin
                        if (pc[AW-1:0] != '0) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            code_q  <= ERR_MISALIGN;
                        end else begin
                            state_q <= REQ;
                            addr_q  <= pc;
                            read_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        state_q <= HOLD;
                        instr_q <= rd_swapped;
                        valid_q <= 1'b1;
                        read_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        // A zero limit means wait forever.
                        if (TIMEOUT_CYCLES != 0 && cnt_d == TMO) begin
                            state_q <= ERR;
                            read_q  <= 1'b0;
                            err_q   <= 1'b1;
                            code_q  <= ERR_TIMEOUT;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ERR: begin
                    read_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_byteenable = read_q ? 4'hF : 4'h0;
    assign instr_word     = instr_q;
    assign instr_valid    = valid_q;
    assign busy           = (state_q != IDLE);
    assign fetch_error    = err_q;
    assign error_code     = code_q;

endmodule

// File: tb/tb_mips_cpu_fetch_unit.sv
// Directed bench for mips_cpu_fetch_unit: default instance plus a
// short-timeout instance sharing the same stimulus.
module tb_mips_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] pc;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        instr_ready;

    logic [31:0] avm_address, t_avm_address;
    logic        avm_read, t_avm_read;
    logic [3:0]  avm_byteenable, t_avm_byteenable;
    logic [31:0] instr_word, t_instr_word;
    logic        instr_valid, t_instr_valid;
    logic        busy, t_busy;
    logic        fetch_error, t_fetch_error;
    logic [1:0]  error_code, t_error_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_cpu_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req),
        .pc              (pc),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .instr_word      (instr_word),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .busy            (busy),
        .fetch_error     (fetch_error),
        .error_code      (error_code)
    );

    mips_cpu_fetch_unit #(
        .BYTE_SWAP      (1'b1),
        .TIMEOUT_CYCLES (4)
    ) dut_t (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req),
        .pc              (pc),
        .avm_address     (t_avm_address),
        .avm_read        (t_avm_read),
        .avm_byteenable  (t_avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .instr_word      (t_instr_word),
        .instr_valid     (t_instr_valid),
        .instr_ready     (instr_ready),
        .busy            (t_busy),
        .fetch_error     (t_fetch_error),
        .error_code      (t_error_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b2b_rd  [3];
    logic [31:0] b2b_exp [3];

    initial begin
        b2b_rd[0]  = 32'h11223344; b2b_exp[0] = 32'h44332211;
        b2b_rd[1]  = 32'h55667788; b2b_exp[1] = 32'h88776655;
        b2b_rd[2]  = 32'h99AABBCC; b2b_exp[2] = 32'hCCBBAA99;

        rst_n = 1'b0;
        fetch_req = 1'b1;
        pc = 32'h0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        instr_ready = 1'b0;

        // Reset held with fetch_req high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_read", 32'(avm_read), 32'd0);
            chk("rst_addr", avm_address, 32'd0);
            chk("rst_be", 32'(avm_byteenable), 32'd0);
            chk("rst_word", instr_word, 32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(fetch_error), 32'd0);
            chk("rst_code", 32'(error_code), 32'd0);
        end
        fetch_req = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_read", 32'(avm_read), 32'd0);

        // Zero-wait fetch
        pc = 32'hBFC00000;
        avm_readdata = 32'h78563412;
        instr_ready = 1'b1;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("zw_read", 32'(avm_read), 32'd1);
        chk("zw_addr", avm_address, 32'hBFC00000);
        chk("zw_be", 32'(avm_byteenable), 32'hF);
        chk("zw_busy", 32'(busy), 32'd1);
        chk("zw_valid0", 32'(instr_valid), 32'd0);
        step();
        chk("zw_read_drop", 32'(avm_read), 32'd0);
        chk("zw_be_drop", 32'(avm_byteenable), 32'd0);
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_word", instr_word, 32'h12345678);
        step();
        chk("zw_valid_clr", 32'(instr_valid), 32'd0);
        chk("zw_idle", 32'(busy), 32'd0);
        step();
        chk("zw_no_read", 32'(avm_read), 32'd0);

        // Stalled fetch and stalled hand-off
        pc = 32'h00400000;
        avm_readdata = 32'hAABBCCDD;
        avm_waitrequest = 1'b1;
        instr_ready = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("st_read", 32'(avm_read), 32'd1);
            chk("st_addr", avm_address, 32'h00400000);
            chk("st_valid0", 32'(instr_valid), 32'd0);
            step();
        end
        chk("st_read6", 32'(avm_read), 32'd1);
        chk("st_err", 32'(fetch_error), 32'd0);
        avm_waitrequest = 1'b0;
        step();
        chk("st_read_drop", 32'(avm_read), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("st_valid", 32'(instr_valid), 32'd1);
            chk("st_word", instr_word, 32'hDDCCBBAA);
            chk("st_busy", 32'(busy), 32'd1);
            if (i < 3) step();
        end
        instr_ready = 1'b1;
        step();
        chk("st_valid_clr", 32'(instr_valid), 32'd0);
        chk("st_idle", 32'(busy), 32'd0);

        // Misaligned pc
        pc = 32'h00000006;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("ma_read", 32'(avm_read), 32'd0);
        chk("ma_err", 32'(fetch_error), 32'd1);
        chk("ma_code", 32'(error_code), 32'd1);
        chk("ma_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'(i % 2);
            step();
            chk("ma_sticky_err", 32'(fetch_error), 32'd1);
            chk("ma_sticky_code", 32'(error_code), 32'd1);
            chk("ma_no_read", 32'(avm_read), 32'd0);
        end
        fetch_req = 1'b0;
        rst_n = 1'b0;
        step();
        chk("ma_rst_err", 32'(fetch_error), 32'd0);
        chk("ma_rst_code", 32'(error_code), 32'd0);
        chk("ma_rst_busy", 32'(busy), 32'd0);
        chk("t_pre_err", 32'(t_fetch_error), 32'd0);
        rst_n = 1'b1;

        // Bus timeout on the 4-cycle instance
        pc = 32'h00000100;
        avm_waitrequest = 1'b1;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_read", 32'(t_avm_read), 32'd1);
            chk("to_addr", t_avm_address, 32'h00000100);
            chk("to_no_err", 32'(t_fetch_error), 32'd0);
            step();
        end
        chk("to_read_drop", 32'(t_avm_read), 32'd0);
        chk("to_err", 32'(t_fetch_error), 32'd1);
        chk("to_code", 32'(t_error_code), 32'd2);
        chk("to_busy", 32'(t_busy), 32'd1);
        chk("to_dflt_wait", 32'(avm_read), 32'd1);
        step();
        chk("to_sticky", 32'(t_error_code), 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        avm_waitrequest = 1'b0;
        chk("to_rst_err", 32'(t_fetch_error), 32'd0);
        chk("to_rst_busy", 32'(t_busy), 32'd0);
        chk("to_rst_read", 32'(t_avm_read), 32'd0);

        // Back-to-back: one word per 3 cycles
        instr_ready = 1'b1;
        fetch_req = 1'b1;
        pc = 32'h00001000;
        for (int k = 0; k < 3; k++) begin
            avm_readdata = b2b_rd[k];
            step();
            chk("bb_read", 32'(avm_read), 32'd1);
            chk("bb_addr", avm_address, 32'h00001000 + 32'(4 * k));
            step();
            pc = 32'h00001000 + 32'(4 * (k + 1));
            chk("bb_valid", 32'(instr_valid), 32'd1);
            chk("bb_word", instr_word, b2b_exp[k]);
            step();
            chk("bb_valid_clr", 32'(instr_valid), 32'd0);
            chk("bb_idle", 32'(busy), 32'd0);
        end
        fetch_req = 1'b0;
        step();
        chk("bb_end_read", 32'(avm_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
